// File: rtl/rat_ctrl.sv
// Rename-stage RAT sequencer: arbitrates dispatch renames, CDB wakeups
// and the identity-init / RRAT-restore walks onto the RAT write ports.
module rat_ctrl #(
   parameter int NUM_ARCH = 32,
   parameter int NUM_PHYS = 64,
   parameter int PW       = $clog2(NUM_PHYS),
   parameter int AW       = $clog2(NUM_ARCH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          disp_valid,
   input  logic [AW-1:0] disp_rd,
   input  logic [PW-1:0] disp_pd,
   output logic          disp_ready,
   input  logic          cdb_valid,
   input  logic [PW-1:0] cdb_pd,
   input  logic          flush_req,
   output logic [AW-1:0] rrat_idx,
   input  logic [PW-1:0] rrat_pd,
   output logic          rat_we,
   output logic [AW-1:0] rat_rd,
   output logic [PW-1:0] rat_pd,
   output logic          rat_valid_wr,
   output logic          rat_cdb_we,
   output logic [PW-1:0] rat_cdb_pd,
   output logic          busy,
   output logic          recover_done
);

   typedef enum logic [1:0] {
      S_INIT,
      S_IDLE,
      S_RECOVER,
      S_DONE
   } state_e;

   localparam logic [AW-1:0] LAST = AW'(NUM_ARCH - 1);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         S_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = S_DONE;
         end
         S_IDLE: begin
            if (flush_req) begin
               state_d = S_RECOVER;
               cnt_d   = '0;
            end
         end
         S_RECOVER: begin
            if (flush_req) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == LAST) state_d = S_DONE;
            end
         end
         S_DONE: begin
            cnt_d   = '0;
            state_d = flush_req ? S_RECOVER : S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Outputs are gated by rst so an async reset silences them at once.
   always_comb begin
      disp_ready   = 1'b0;
      rrat_idx     = '0;
      rat_we       = 1'b0;
      rat_rd       = '0;
      rat_pd       = '0;
      rat_valid_wr = 1'b0;
      rat_cdb_we   = 1'b0;
      rat_cdb_pd   = '0;
      busy         = 1'b0;
      recover_done = 1'b0;
      if (rst) begin
         unique case (state_q)
            S_INIT: begin
               rat_we       = 1'b1;
               rat_rd       = cnt_q;
               rat_pd       = PW'(cnt_q);
               rat_valid_wr = 1'b1;
               busy         = 1'b1;
            end
            S_IDLE: begin
               disp_ready = !flush_req;
               rat_we     = disp_valid && !flush_req
                            && (disp_rd != '0);
               rat_rd     = disp_rd;
               rat_pd     = disp_pd;
               rat_cdb_we = cdb_valid && !flush_req;
               rat_cdb_pd = cdb_pd;
            end
            S_RECOVER: begin
               rrat_idx     = cnt_q;
               rat_we       = 1'b1;
               rat_rd       = cnt_q;
               rat_pd       = rrat_pd;
               rat_valid_wr = 1'b1;
               busy         = 1'b1;
            end
            S_DONE: begin
               recover_done = 1'b1;
               busy         = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rat_ctrl.sv
// Bench for rat_ctrl: IDLE vector table, directed walk/flush/reset
// sequences and a randomized run against a walk-position model.
module tb_rat_ctrl;

   localparam int NA = 32;
   localparam int NP = 64;
   localparam int PW = 6;
   localparam int AW = 5;

   logic          clk = 1'b0;
   logic          rst;
   logic          disp_valid;
   logic [AW-1:0] disp_rd;
   logic [PW-1:0] disp_pd;
   logic          disp_ready;
   logic          cdb_valid;
   logic [PW-1:0] cdb_pd;
   logic          flush_req;
   logic [AW-1:0] rrat_idx;
   logic [PW-1:0] rrat_pd;
   logic          rat_we;
   logic [AW-1:0] rat_rd;
   logic [PW-1:0] rat_pd;
   logic          rat_valid_wr;
   logic          rat_cdb_we;
   logic [PW-1:0] rat_cdb_pd;
   logic          busy;
   logic          recover_done;

   logic [PW-1:0] rrat_tab [NA];

   assign rrat_pd = rrat_tab[rrat_idx];

   always #5 clk = ~clk;

   rat_ctrl #(
      .NUM_ARCH(NA),
      .NUM_PHYS(NP)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .disp_valid  (disp_valid),
      .disp_rd     (disp_rd),
      .disp_pd     (disp_pd),
      .disp_ready  (disp_ready),
      .cdb_valid   (cdb_valid),
      .cdb_pd      (cdb_pd),
      .flush_req   (flush_req),
      .rrat_idx    (rrat_idx),
      .rrat_pd     (rrat_pd),
      .rat_we      (rat_we),
      .rat_rd      (rat_rd),
      .rat_pd      (rat_pd),
      .rat_valid_wr(rat_valid_wr),
      .rat_cdb_we  (rat_cdb_we),
      .rat_cdb_pd  (rat_cdb_pd),
      .busy        (busy),
      .recover_done(recover_done)
   );

   int tests = 0;
   int fails = 0;

   // Model: m_pos = -1 idle, 0..NA-1 walk slot, NA = completion cycle.
   int m_pos  = 0;
   bit m_init = 1'b1;

   bit obs_done, obs_we, obs_vwr, obs_ready;
   int obs_rd;

   typedef struct {
      bit            dv;
      logic [AW-1:0] rd;
      logic [PW-1:0] pd;
      bit            cv;
      logic [PW-1:0] cpd;
      bit            fl;
      bit            e_rdy;
      bit            e_we;
      int            e_rd;
      int            e_pd;
      bit            e_cwe;
      int            e_cpd;
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  nm, act, exp, $time);
      end
   endtask

   task automatic chk_zero();
      chk("rst_ready", int'(disp_ready), 0);
      chk("rst_we", int'(rat_we), 0);
      chk("rst_rd", int'(rat_rd), 0);
      chk("rst_pd", int'(rat_pd), 0);
      chk("rst_vwr", int'(rat_valid_wr), 0);
      chk("rst_cwe", int'(rat_cdb_we), 0);
      chk("rst_cpd", int'(rat_cdb_pd), 0);
      chk("rst_ridx", int'(rrat_idx), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(recover_done), 0);
   endtask

   task automatic check_model();
      int e_rdy, e_we, e_cwe, e_done, e_busy;
      if (m_pos < 0) begin
         e_rdy  = int'(!flush_req);
         e_we   = int'(disp_valid && !flush_req && disp_rd != 0);
         e_cwe  = int'(cdb_valid && !flush_req);
         e_done = 0;
         e_busy = 0;
      end else if (m_pos < NA) begin
         e_rdy = 0; e_we = 1; e_cwe = 0; e_done = 0; e_busy = 1;
      end else begin
         e_rdy = 0; e_we = 0; e_cwe = 0; e_done = 1; e_busy = 1;
      end
      chk("disp_ready", int'(disp_ready), e_rdy);
      chk("rat_we", int'(rat_we), e_we);
      chk("rat_cdb_we", int'(rat_cdb_we), e_cwe);
      chk("recover_done", int'(recover_done), e_done);
      chk("busy", int'(busy), e_busy);
      if (e_we != 0) begin
         if (m_pos < 0) begin
            chk("disp_rd", int'(rat_rd), int'(disp_rd));
            chk("disp_pd", int'(rat_pd), int'(disp_pd));
            chk("disp_vwr", int'(rat_valid_wr), 0);
         end else begin
            chk("walk_rd", int'(rat_rd), m_pos);
            chk("walk_pd", int'(rat_pd),
                m_init ? m_pos : int'(rrat_tab[m_pos]));
            chk("walk_vwr", int'(rat_valid_wr), 1);
            if (!m_init) chk("rrat_idx", int'(rrat_idx), m_pos);
         end
      end
      if (e_cwe != 0) chk("cdb_pd", int'(rat_cdb_pd), int'(cdb_pd));
   endtask

   task automatic model_step();
      if (m_pos < 0) begin
         if (flush_req) begin
            m_pos  = 0;
            m_init = 1'b0;
         end
      end else if (flush_req && !(m_init && m_pos < NA)) begin
         m_pos  = 0;
         m_init = 1'b0;
      end else if (m_pos == NA) begin
         m_pos = -1;
      end else begin
         m_pos++;
      end
   endtask

   // Entered and left at posedge+1.
   task automatic cyc(input bit dv, input int rd, input int pd,
                      input bit cv, input int cpd, input bit fl);
      disp_valid = dv;
      disp_rd    = AW'(rd);
      disp_pd    = PW'(pd);
      cdb_valid  = cv;
      cdb_pd     = PW'(cpd);
      flush_req  = fl;
      #2;
      check_model();
      obs_done  = recover_done;
      obs_we    = rat_we;
      obs_vwr   = rat_valid_wr;
      obs_ready = disp_ready;
      obs_rd    = int'(rat_rd);
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_n(input int n);
      for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0);
   endtask

   vec_t vt [8];

   initial begin
      int first_done, acc;
      rst = 1'b0;
      disp_valid = 0; disp_rd = 0; disp_pd = 0;
      cdb_valid = 0; cdb_pd = 0; flush_req = 0;
      for (int i = 0; i < NA; i++) rrat_tab[i] = PW'(i + 32);

      // Reset state, then INIT walk with a flush and a dispatch ignored
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk_zero();
      rst = 1'b1;
      m_pos = 0; m_init = 1'b1;
      first_done = -1;
      for (int k = 0; k < NA + 3; k++) begin
         cyc(1, 4, 44, 1, 9, k == 5);
         if (obs_done && first_done < 0) first_done = k;
      end
      chk("init_done_cycle", first_done, NA);

      // IDLE vector table
      vt[0] = '{1, 1, 32, 0, 0, 0, 1, 1, 1, 32, 0, 0};
      vt[1] = '{1, 0, 40, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      vt[2] = '{0, 0, 0, 1, 32, 0, 1, 0, 0, 0, 1, 32};
      vt[3] = '{1, 5, 50, 1, 7, 0, 1, 1, 5, 50, 1, 7};
      vt[4] = '{1, 3, 33, 0, 0, 1, 0, 0, 0, 0, 0, 0};
      vt[5] = '{0, 0, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0};
      vt[6] = '{0, 9, 20, 0, 0, 0, 1, 0, 0, 0, 0, 0};
      vt[7] = '{1, 31, 63, 1, 63, 0, 1, 1, 31, 63, 1, 63};
      for (int i = 0; i < 8; i++) begin
         disp_valid = vt[i].dv;
         disp_rd    = vt[i].rd;
         disp_pd    = vt[i].pd;
         cdb_valid  = vt[i].cv;
         cdb_pd     = vt[i].cpd;
         flush_req  = vt[i].fl;
         #2;
         chk($sformatf("vec%0d_ready", i), int'(disp_ready),
             int'(vt[i].e_rdy));
         chk($sformatf("vec%0d_we", i), int'(rat_we), int'(vt[i].e_we));
         if (vt[i].e_we) begin
            chk($sformatf("vec%0d_rd", i), int'(rat_rd), vt[i].e_rd);
            chk($sformatf("vec%0d_pd", i), int'(rat_pd), vt[i].e_pd);
            chk($sformatf("vec%0d_vwr", i), int'(rat_valid_wr), 0);
         end
         chk($sformatf("vec%0d_cwe", i), int'(rat_cdb_we),
             int'(vt[i].e_cwe));
         if (vt[i].e_cwe)
            chk($sformatf("vec%0d_cpd", i), int'(rat_cdb_pd), vt[i].e_cpd);
         flush_req = 1'b0;
         @(posedge clk);
         model_step();
         #1;
      end

      // Flush recovery, dispatch and CDB held throughout
      first_done = -1; acc = -1;
      for (int k = 0; k < NA + 4; k++) begin
         cyc(1, 3, 50, 1, 32, k == 0);
         if (obs_done && first_done < 0) first_done = k;
         if (obs_we && !obs_vwr && obs_rd == 3 && acc < 0) acc = k;
      end
      chk("flush_done_cycle", first_done, NA + 1);
      chk("flush_accept_cycle", acc, NA + 2);

      // Second flush at walk cnt=10 restarts at index 0
      first_done = -1; acc = -1;
      for (int k = 0; k < NA + 16; k++) begin
         cyc(0, 0, 0, 0, 0, k == 0 || k == 11);
         if (k == 12) acc = obs_rd;
         if (obs_done && first_done < 0) first_done = k;
      end
      chk("reflush_rd", acc, 0);
      chk("reflush_done_cycle", first_done, 11 + NA + 1);

      // Async reset at walk cnt=17
      cyc(0, 0, 0, 0, 0, 1);
      idle_n(17);
      #2;
      chk("pre_rst_rd", int'(rat_rd), 17);
      rst = 1'b0;
      #1;
      chk_zero();
      @(posedge clk); #1;
      chk_zero();
      rst = 1'b1;
      m_pos = 0; m_init = 1'b1;
      cyc(0, 0, 0, 0, 0, 0);
      chk("reinit_rd0", obs_rd, 0);
      idle_n(NA + 2);

      // Randomized run
      for (int i = 0; i < NA; i++) rrat_tab[i] = PW'($urandom);
      for (int n = 0; n < 3000; n++) begin
         cyc(bit'($urandom % 2), int'($urandom % NA), int'($urandom % NP),
             bit'($urandom % 2), int'($urandom % NP), ($urandom % 40) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
